// File: rtl/pulse_sync_arb_pkg.sv
// Shared types and constants for the pulse synchronizer arbiter.
package pulse_sync_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    GAP
  } state_t;

  localparam int CNT_W = 8;

  // A single requester still needs a one-bit index.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_sync_arbiter_if.sv
// Requester/synchronizer-facing signal bundle of the pulse synchronizer arbiter.
interface pulse_sync_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import pulse_sync_arb_pkg::*;

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic               ack_in;
  logic               ovf_clr;
  logic               pulse_out;
  logic [ID_W-1:0]    id_out;
  logic               busy;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] overflow;
  logic               timeout_err;

  modport master (
    output req, ack_in, ovf_clr,
    input  pulse_out, id_out, busy, done, overflow, timeout_err
  );

  modport slave (
    input  req, ack_in, ovf_clr,
    output pulse_out, id_out, busy, done, overflow, timeout_err
  );

endinterface

// File: rtl/pulse_sync_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_arbiter
  import pulse_sync_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_idx
);
  localparam int OFF_W = ID_W + 1;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [OFF_W-1:0]     offset;
  logic [OFF_W-1:0]     sum;

  // Rotating a doubled copy puts the ptr position at bit 0.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[{1'b0, ptr} +: NUM_REQ];

  always_comb begin
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        offset = OFF_W'(k);
      end
    end
    sum = {1'b0, ptr} + offset;
    if (sum >= OFF_W'(NUM_REQ)) begin
      sum = sum - OFF_W'(NUM_REQ);
    end
  end

  assign grant_valid = |req;
  assign grant_idx   = ID_W'(sum);

endmodule

// File: rtl/pulse_sync_arbiter.sv
// Shares one pulse synchronizer among NUM_REQ event sources: sticky capture,
// round-robin launch of a fixed-width pulse, ack wait with timeout, guard gap.
module pulse_sync_arbiter
  import pulse_sync_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PULSE_WIDTH = 1,
  parameter int GAP_CYCLES  = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pulse_sync_arbiter_if.slave  bus
);
  localparam int ID_W = id_width(NUM_REQ);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  // GAP always occupies at least one cycle, so a zero gap still passes through it.
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [NUM_REQ-1:0] pending_reg, pending_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [ID_W-1:0]    id_reg, id_next;
  logic               pulse_reg, pulse_next;
  logic               busy_reg, busy_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [NUM_REQ-1:0] ovf_reg, ovf_next;
  logic               tmo_reg, tmo_next;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant_mask;
  logic [NUM_REQ-1:0] new_ovf;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_idx;
  logic               do_grant;
  logic               timeout_hit;

  assign arb_req = pending_reg | bus.req;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req        (arb_req),
    .ptr        (ptr_reg),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  assign do_grant    = (state_reg == IDLE) && grant_valid;
  assign timeout_hit = (state_reg == WAIT_ACK) && !bus.ack_in && (cnt_reg == ACK_LAST);

  // A req landing on the cycle its pending bit is granted is a fresh event.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign grant_mask[gi]   = do_grant && (grant_idx == ID_W'(gi));
      assign pending_next[gi] = grant_mask[gi] ? (pending_reg[gi] & bus.req[gi])
                                               : (pending_reg[gi] | bus.req[gi]);
      assign new_ovf[gi]      = bus.req[gi] & pending_reg[gi] & ~grant_mask[gi];
    end
  endgenerate

  assign ovf_next = (bus.ovf_clr ? '0 : ovf_reg) | new_ovf;
  assign tmo_next = (tmo_reg & ~bus.ovf_clr) | timeout_hit;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    done_next  = '0;
    unique case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next = LAUNCH;
          cnt_next   = '0;
          id_next    = grant_idx;
          ptr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
      end
      LAUNCH: begin
        if (cnt_reg == PULSE_LAST) begin
          state_next = WAIT_ACK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (bus.ack_in) begin
          state_next = GAP;
          cnt_next   = '0;
          done_next  = NUM_REQ'(1) << id_reg;
        end else if (cnt_reg == ACK_LAST) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign pulse_next = (state_next == LAUNCH);
  assign busy_next  = (state_next != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pending_reg <= '0;
      ptr_reg     <= '0;
      id_reg      <= '0;
      pulse_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= '0;
      ovf_reg     <= '0;
      tmo_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      ptr_reg     <= ptr_next;
      id_reg      <= id_next;
      pulse_reg   <= pulse_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      ovf_reg     <= ovf_next;
      tmo_reg     <= tmo_next;
    end
  end

  assign bus.pulse_out   = pulse_reg;
  assign bus.id_out      = id_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.overflow    = ovf_reg;
  assign bus.timeout_err = tmo_reg;

endmodule

// File: tb/tb_pulse_sync_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, randomized run vs rule-level model.
module tb_pulse_sync_arbiter;
  localparam int N  = 4;
  localparam int PW = 1;
  localparam int G  = 3;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pulse_sync_arbiter_if #(.NUM_REQ(N)) bus ();

  pulse_sync_arbiter #(
    .NUM_REQ    (N),
    .PULSE_WIDTH(PW),
    .GAP_CYCLES (G),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] req;
    logic         ack;
    logic         clr;
    logic         pulse;
    logic         busy;
    logic [1:0]   id;
    logic [N-1:0] done;
    logic [N-1:0] ovf;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req     = '0;
    bus.ack_in  = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [12:0] out_vec();
    return {bus.pulse_out, bus.busy, bus.id_out, bus.done, bus.overflow, bus.timeout_err};
  endfunction

  // Ticks until pulse_out rises (bounded); caller has set req for the first cycle.
  task automatic next_launch(input int exp_id, input int exp_ticks, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      bus.req = '0;
      bus.ovf_clr = 1'b0;
      n++;
    end while (!bus.pulse_out && n < 60);
    check({tag, "_wait"}, n, exp_ticks);
    check({tag, "_id"}, bus.id_out, exp_id);
  endtask

  // From the first pulse cycle: finish the pulse, ack one cycle into WAIT_ACK, check done.
  task automatic finish_transfer(input int id, input logic [N-1:0] extra_req, input string tag);
    repeat (PW - 1) tick();
    bus.req = extra_req;
    tick();
    bus.req = '0;
    check({tag, "_pulse_low"}, bus.pulse_out, 0);
    tick();
    bus.ack_in = 1'b1;
    tick();
    bus.ack_in = 1'b0;
    check({tag, "_done"}, bus.done, 32'(1) << id);
  endtask

  function automatic int rr_pick(input bit [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Rule-level model: outstanding events per requester, grants whenever the
  // arbiter was idle the previous cycle, busy window derived from launch/ack times.
  task automatic run_random(input int ncyc, input int ndrain);
    bit [N-1:0] outst, ovf_m, prev_req, cand, gmask, new_ovf, exp_done, rq;
    bit prev_ack_planned, prev_clr, prev_busy, inflight, exp_busy, exp_pulse, planned, spurious;
    int ptr_m, cur_id, launch_t, ack_at, busy_until, g;
    outst = '0; ovf_m = '0; prev_req = '0;
    prev_ack_planned = 0; prev_clr = 0; prev_busy = 0; inflight = 0;
    ptr_m = 0; cur_id = 0; launch_t = 0; ack_at = -1; busy_until = -1;
    for (int t = 1; t <= ncyc + ndrain; t++) begin
      tick();
      exp_done = '0;
      if (prev_ack_planned) begin
        exp_done   = bit'(1) << cur_id;
        inflight   = 0;
        busy_until = (t - 1) + ((G > 0) ? G : 1);
      end
      cand = outst | prev_req;
      if (!prev_busy && cand != 0) begin
        g        = rr_pick(cand, ptr_m);
        gmask    = '0;
        gmask[g] = 1'b1;
        new_ovf  = prev_req & outst & ~gmask;
        outst    = (cand & ~gmask) | (outst & prev_req & gmask);
        cur_id   = g;
        ptr_m    = (g + 1) % N;
        inflight = 1;
        launch_t = t;
        ack_at   = t + PW + $urandom_range(0, 4);
        busy_until = 1 << 30;
      end else begin
        new_ovf = prev_req & outst;
        outst   = cand;
      end
      ovf_m     = (prev_clr ? '0 : ovf_m) | new_ovf;
      exp_busy  = (t <= busy_until);
      exp_pulse = inflight && (t < launch_t + PW);
      check($sformatf("rnd_c%0d", t), out_vec(),
            {exp_pulse, exp_busy, 2'(cur_id), exp_done, ovf_m, 1'b0});
      prev_busy = exp_busy;

      for (int i = 0; i < N; i++) rq[i] = (t <= ncyc) && ($urandom_range(0, 7) == 0);
      planned  = inflight && (t == ack_at);
      spurious = !planned && !(inflight && t >= launch_t + PW && t <= ack_at)
                 && ($urandom_range(0, 15) == 0);
      bus.req     = rq;
      bus.ack_in  = planned | spurious;
      bus.ovf_clr = ($urandom_range(0, 31) == 0);
      prev_req = rq;
      prev_ack_planned = planned;
      prev_clr = bus.ovf_clr;
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit any_done, seen;

    // req, ack, clr -> pulse, busy, id, done, overflow (observed after the next edge)
    vecs = '{
      '{4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000},
      '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000},
      '{4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000},
      '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000},
      '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0100},
      '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0100},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0100},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0100},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0100},
      '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0100},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0100},
      '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000},
      '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000}
    };

    // Reset state, then single transfer, gap timing and overflow/clear from the table.
    do_reset();
    check("reset_state", out_vec(), 0);
    for (int k = 0; k < 21; k++) begin
      bus.req     = vecs[k].req;
      bus.ack_in  = vecs[k].ack;
      bus.ovf_clr = vecs[k].clr;
      tick();
      check($sformatf("vec%0d", k),
            {bus.pulse_out, bus.busy, bus.id_out, bus.done, bus.overflow},
            {vecs[k].pulse, vecs[k].busy, vecs[k].id, vecs[k].done, vecs[k].ovf});
    end
    idle_inputs();

    // Round-robin order 0,1,3 then wrap to 0; exact back-to-back spacing.
    do_reset();
    bus.req = 4'b1011;
    next_launch(0, 1, "t2_l0");
    finish_transfer(0, 4'b0000, "t2_x0");
    next_launch(1, G + 1, "t2_l1");
    finish_transfer(1, 4'b0001, "t2_x1");
    next_launch(3, G + 1, "t2_l3");
    finish_transfer(3, 4'b0000, "t2_x3");
    next_launch(0, G + 1, "t2_l0b");
    finish_transfer(0, 4'b0000, "t2_x0b");
    seen = 0;
    repeat (12) begin
      tick();
      seen |= bus.pulse_out;
    end
    check("t2_no_extra_launch", seen, 0);

    // Ack timeout: error 15 cycles after pulse falls, no done, queued request proceeds.
    do_reset();
    bus.req = 4'b0010;
    next_launch(1, 1, "t4_l1");
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    n = 0;
    any_done = 0;
    while (!bus.timeout_err && n < 40) begin
      tick();
      n++;
      any_done |= (bus.done != 0);
    end
    check("t4_timeout_delay", n, TO);
    check("t4_no_done", any_done, 0);
    next_launch(2, G + 1, "t4_l2");
    finish_transfer(2, 4'b0000, "t4_x2");
    check("t4_err_sticky", bus.timeout_err, 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t4_err_cleared", bus.timeout_err, 0);

    // req[1] in the very cycle pending[1] is granted: two launches, no overflow.
    do_reset();
    bus.req = 4'b0001;
    next_launch(0, 1, "t5_l0");
    finish_transfer(0, 4'b0010, "t5_x0");
    repeat (G) tick();
    check("t5_idle", bus.busy, 0);
    bus.req = 4'b0010;
    next_launch(1, 1, "t5_l1a");
    finish_transfer(1, 4'b0000, "t5_x1a");
    next_launch(1, G + 1, "t5_l1b");
    finish_transfer(1, 4'b0000, "t5_x1b");
    check("t5_no_overflow", bus.overflow, 0);

    // Asynchronous reset during WAIT_ACK discards in-flight and pending events.
    do_reset();
    bus.req = 4'b0001;
    next_launch(0, 1, "t6_l0");
    bus.req = 4'b1100;
    tick();
    bus.req = '0;
    tick();
    check("t6_pre_busy", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", out_vec(), 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      seen |= bus.busy | bus.pulse_out;
    end
    check("t6_no_launch", seen, 0);
    bus.req = 4'b0100;
    next_launch(2, 1, "t6_l2");
    finish_transfer(2, 4'b0000, "t6_x2");

    // Randomized traffic against the rule-level model.
    do_reset();
    run_random(800, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
